// File: rtl/mdu_ctrl_if.sv
// MDU_CTRL pipeline-side interface: issue controls, status and HI/LO outputs.
// The pipeline drives the master modport; mdu_ctrl uses the slave modport.
interface mdu_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hilo;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, rd_hilo,
    input  busy, stall, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, rd_hilo,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// MDU_CTRL: MIPS-style multiply/divide unit with HI/LO registers.
// Iterative radix-2 multiply and restoring divide, 33 cycles from issue to
// HI/LO write. Optional macro MDU_FAST_MULT_EN: mult/multu use a
// combinational 64-bit product written at the issue edge.
module mdu_ctrl (
  input  logic       clk,
  input  logic       reset,
  mdu_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;     // mult: {partial, multiplier}; div: {remainder, quotient}
  logic [31:0] dvs_q;     // multiplicand or divisor magnitude
  logic        is_div_q;
  logic        neg_hi_q;  // product sign (mult) or remainder sign (div)
  logic        neg_lo_q;  // quotient sign
  logic        divz_q;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        busy;
  logic        sgn;
  logic        iter_op;
  logic        load_en;
  logic [31:0] abs_a, abs_b;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;
  logic [63:0] acc_neg;
  logic [31:0] quo_neg, rem_neg;

`ifdef MDU_FAST_MULT_EN
  logic [63:0] ext_a, ext_b;
  logic [63:0] fast_prod;
`endif

  assign busy      = (state_q != IDLE);
  assign bus.busy  = busy;
  assign bus.stall = busy & (bus.rd_hilo | bus.start);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Operand magnitudes: op[0] clear selects the signed variant
  always_comb begin
    sgn   = ~bus.op[0];
    abs_a = (sgn & bus.a[31]) ? (32'd0 - bus.a) : bus.a;
    abs_b = (sgn & bus.b[31]) ? (32'd0 - bus.b) : bus.b;
`ifdef MDU_FAST_MULT_EN
    iter_op = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
`else
    iter_op = (bus.op == OP_MULT) || (bus.op == OP_MULTU) ||
              (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
`endif
    load_en = (state_q == IDLE) & bus.start & iter_op;
  end

`ifdef MDU_FAST_MULT_EN
  // Full-width product; low 64 bits of sign/zero-extended operands
  always_comb begin
    ext_a     = bus.op[0] ? {32'd0, bus.a} : {{32{bus.a[31]}}, bus.a};
    ext_b     = bus.op[0] ? {32'd0, bus.b} : {{32{bus.b[31]}}, bus.b};
    fast_prod = ext_a * ext_b;
  end
`endif

  // One iteration of shift-add multiply and restoring divide, plus sign fixes
  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvs_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = acc_q[63:31];
    div_ge    = (div_shift >= {1'b0, dvs_q});
    div_diff  = div_shift[31:0] - dvs_q;
    div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};
    acc_neg   = 64'd0 - acc_q;
    quo_neg   = 32'd0 - acc_q[31:0];
    rem_neg   = 32'd0 - acc_q[63:32];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_en) state_d = RUN;
      RUN:     if (cnt_q == 5'd31) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writes and done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
      divz_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_en) begin
            acc_q    <= {32'd0, abs_a};
            dvs_q    <= abs_b;
            is_div_q <= bus.op[1];
            neg_hi_q <= bus.op[1] ? (sgn & bus.a[31]) : (sgn & (bus.a[31] ^ bus.b[31]));
            neg_lo_q <= sgn & (bus.a[31] ^ bus.b[31]);
            divz_q   <= bus.op[1] & (bus.b == 32'd0);
            cnt_q    <= '0;
          end else if (bus.start) begin
            case (bus.op)
`ifdef MDU_FAST_MULT_EN
              OP_MULT, OP_MULTU: begin
                hi_q   <= fast_prod[63:32];
                lo_q   <= fast_prod[31:0];
                done_q <= 1'b1;
              end
`endif
              OP_MTHI: hi_q <= bus.a;
              OP_MTLO: lo_q <= bus.a;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc_q <= is_div_q ? div_next : mul_next;
          if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
        end
        FIX: begin
          // Divide by zero leaves all-ones quotient; remainder recovers a
          if (is_div_q) begin
            lo_q <= divz_q ? '1 : (neg_lo_q ? quo_neg : acc_q[31:0]);
            hi_q <= neg_hi_q ? rem_neg : acc_q[63:32];
          end else begin
            hi_q <= neg_hi_q ? acc_neg[63:32] : acc_q[63:32];
            lo_q <= neg_hi_q ? acc_neg[31:0]  : acc_q[31:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: randomized and directed operations checked by a
// done-driven scoreboard against an arithmetic reference model.
module tb_mdu_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  mdu_ctrl_if bus ();

  mdu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          errs    = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on the operation definitions, {hi, lo}
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    res = '0;
    case (op)
      3'b000: res = sa * sbv;
      3'b001: res = {32'd0, a} * {32'd0, b};
      3'b010, 3'b011: begin
        if (b == 32'd0) res = {a, 32'hFFFFFFFF};
        else if (op == 3'b010) begin
          q   = sa / sbv;
          r   = sa % sbv;
          res = {r[31:0], q[31:0]};
        end else res = {a % b, a / b};
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic int latency(input logic [2:0] op);
`ifdef MDU_FAST_MULT_EN
    if (op == 3'b000 || op == 3'b001) return 0;
`endif
    return 33;
  endfunction

  // Monitor: pops on done, checks values and latency; HI/LO stable while busy
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_hilo"}, {bus.hi, bus.lo}, {e.hi, e.lo});
          chk({e.name, "_latency"}, 64'(cyc - e.n), 64'(latency_of(e.name)));
          m_hi = e.hi;
          m_lo = e.lo;
        end
      end else if (bus.busy) begin
        chk("hold_during_run", {bus.hi, bus.lo}, {m_hi, m_lo});
      end
    end
  end

  // Latency is encoded by the op class in the entry name
  function automatic int latency_of(input string name);
    if (name == "mul") return latency(3'b000);
    return 33;
  endfunction

  int issue_n;

  // Drive one start for a cycle; checks immediate effects at the sampling edge
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    exp_t e;
    r = ref_model(op, a, b);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    issue_n = cyc;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011: begin
        e.hi = r[63:32]; e.lo = r[31:0]; e.n = cyc;
        e.name = op[1] ? "div" : "mul";
        sb.push_back(e);
        chk("busy_after_issue", 64'(bus.busy), 64'(latency(op) != 0));
      end
      3'b100: begin
        m_hi = a;
        chk("mthi", {bus.hi, bus.lo, 31'd0, bus.busy}, {m_hi, m_lo, 32'd0});
      end
      3'b101: begin
        m_lo = a;
        chk("mtlo", {bus.hi, bus.lo, 31'd0, bus.busy}, {m_hi, m_lo, 32'd0});
      end
      default: chk("ignored_op", {bus.hi, bus.lo, 31'd0, bus.busy}, {m_hi, m_lo, 32'd0});
    endcase
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) begin ok = 1'b1; break; end
    end
    #1;
    if (sb.size() != 0 || bus.busy) ok = 1'b0;
    chk("idle_timeout", 64'(ok), 64'd1);
    sb.delete();
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.rd_hilo = 1'b0;

    #12;
    chk("reset_state", {bus.hi, bus.lo, 29'd0, bus.busy, bus.done, bus.stall}, 96'd0);
    @(negedge clk) reset = 1'b0;

    // Directed arithmetic cases
    issue(3'b000, 32'hFFFFFFFE, 32'd3);          wait_idle();
    chk("mult_m2x3", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFA);
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);   wait_idle();
    chk("multu_max", {m_hi, m_lo}, 64'hFFFFFFFE_00000001);
    issue(3'b010, 32'hFFFFFFF9, 32'd2);          wait_idle();
    chk("div_m7_2", {m_hi, m_lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'b011, 32'd100, 32'd0);               wait_idle();
    chk("divu_by0", {m_hi, m_lo}, 64'h00000064_FFFFFFFF);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);   wait_idle();
    chk("div_ovf", {m_hi, m_lo}, 64'h00000000_80000000);
    issue(3'b010, 32'h80000005, 32'd0);          wait_idle();

    // Stall with rd_hilo from cycle 5; second start at cycle 10 ignored
    issue(3'b010, 32'd1000, 32'd7);
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk); #2;
      if (k == 5)  bus.rd_hilo = 1'b1;
      if (k == 10) begin bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hDEADBEEF; end
      if (k == 11) bus.start = 1'b0;
      @(negedge clk);
      chk("stall_busy", {62'd0, bus.busy, bus.stall},
          {62'd0, (k < 33), (k < 33) && (k >= 5)});
    end
    bus.rd_hilo = 1'b0;
    wait_idle();
    chk("stall_hold_result", {bus.hi, bus.lo}, {32'd6, 32'd142});

    // Reset mid-divide aborts, then first edge after release accepts mtlo
    issue(3'b010, 32'd12345, 32'd17);
    repeat (14) @(posedge clk);
    @(posedge clk); #2 reset = 1'b1;
    #1 chk("reset_abort", {bus.hi, bus.lo, 30'd0, bus.busy, bus.done}, 96'd0);
    sb.delete(); m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'h12345678;
    @(posedge clk); #1;
    m_lo = 32'h12345678;
    chk("mtlo_after_reset", {bus.hi, bus.lo, 31'd0, bus.busy}, {32'd0, 32'h12345678, 32'd0});
    #1 bus.start = 1'b0;

    // Randomized mix including mthi/mtlo, ignored ops and zero divisors
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 40));
      issue(op, a, b);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows: clk input, 1 bit, rising-edge clock; reset input, 1 bit, asynchronous active-high reset.
REQ-002 The block SHALL provide the following ports:
- start: input, 1 bit, issue the operation on op/a/b; sampled on the rising clk edge.
- op: input, 3 bits, operation select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 110 and 111 are ignored.
- a: input, 32 bits, rs operand (multiplicand or dividend, or mthi/mtlo data).
- b: input, 32 bits, rt operand (multiplier or divisor).
- rd_hilo: input, 1 bit, a decode-stage mfhi/mflo is present.
- busy: output, 1 bit, an iterative operation is in progress.
- stall: output, 1 bit, a pipeline freeze request.
- done: output, 1 bit, one-cycle pulse when HI/LO have been updated by mult or div.
- hi: output, 32 bits, HI register.
- lo: output, 32 bits, LO register.

Function
REQ-003 The state machine SHALL have three states, IDLE, RUN and FIX, and busy SHALL equal (state != IDLE).
REQ-004 In IDLE, start with op in {mult, multu, div, divu} SHALL do the following at that edge: latch |a| and |b| (magnitudes for signed ops, raw values for unsigned ops), record the result signs, clear the 5-bit iteration counter, and enter RUN.
REQ-005 RUN SHALL perform one iteration per cycle:
- Multiply: radix-2 shift-add into a 64-bit accumulator.
- Divide: restoring shift-subtract, giving a 32-bit quotient and a 32-bit remainder.
- When counter==31, the next state SHALL be FIX; otherwise counter SHALL increment.
REQ-006 FIX SHALL apply the sign correction and write HI/LO, pulse done for the following cycle, and return to IDLE.
- Sign correction: a negative product is the 64-bit two's complement negation; the quotient sign is a[31]^b[31]; the remainder sign is a[31].
REQ-007 Latency: if start is sampled at edge N, HI/LO SHALL update at edge N+33 and done SHALL be high for exactly one cycle after edge N+33.
REQ-008 The result mapping SHALL be: mult/multu: hi=product[63:32], lo=product[31:0]; div/divu: lo=quotient, hi=remainder.
REQ-009 Divide by zero SHALL complete with the same 33-cycle latency, giving lo=32'hFFFFFFFF and hi=a unmodified, for both div and divu.
REQ-010 Signed div of 32'h80000000 by 32'hFFFFFFFF SHALL give lo=32'h80000000 and hi=0.
REQ-011 mthi and mtlo in IDLE SHALL write a into hi or lo, respectively, at the sampling edge; busy SHALL stay 0 and done SHALL not pulse.
REQ-012 The stall output SHALL be asserted combinationally as busy & (rd_hilo | start).
REQ-013 start while busy SHALL be ignored; the issuing pipeline holds and reissues it once busy is 0.
REQ-014 hi and lo SHALL hold their values at all times except the writes defined in REQ-006 and REQ-011.
REQ-015 A start with an ignored op (110 or 111) SHALL have no effect.
REQ-016 No intermediate value SHALL appear on hi or lo during RUN.

Reset
REQ-017 Reset SHALL force, asynchronously:
- state=IDLE, counter=0, busy=0, done=0;
- hi=0, lo=0;
- all internal operand, accumulator and sign registers to 0.
REQ-018 Reset asserted during RUN or FIX SHALL abort the operation, with no HI/LO write.
REQ-019 After reset is released, the first rising edge SHALL be able to accept start.

Configuration
REQ-020 With macro MDU_FAST_MULT_EN defined, mult and multu SHALL compute the full 64-bit product combinationally and write HI/LO at the sampling edge.
- done SHALL pulse during the next cycle, busy SHALL stay 0, and RUN/FIX SHALL not be entered.
REQ-021 Without MDU_FAST_MULT_EN, mult and multu SHALL use the 33-cycle iterative path.
REQ-022 div and divu SHALL be identical in both configurations.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- mult: a=32'hFFFFFFFE (-2), b=3 -> after 33 cycles hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, done pulsed once; with MDU_FAST_MULT_EN, the same values appear one edge after start and busy never rises.
- multu: a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
- div: a=-7 (32'hFFFFFFF9), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF; divu: a=100, b=0 -> lo=32'hFFFFFFFF, hi=100.
- div in progress with rd_hilo=1 from cycle 5 -> stall=1 through the FIX cycle and 0 after; a second start at cycle 10 is ignored, and hi/lo hold the first result.
- Reset pulsed at RUN cycle 15 of a div -> busy=0 and hi=lo=0 immediately; a following mtlo a=32'h12345678 gives lo=32'h12345678 at that edge.
- Signed div of 32'h80000000 by 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
